// File: rtl/hazard_ctrl.sv
// Hazard and interlock unit: EX/ID forwarding, load-use and branch stalls, and a
// multi-cycle mult/div interlock. Define HAZARD_PERF_EN to add saturating stall counters.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              mdstartE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushE,
  output logic              flushM,
  output logic              mdbusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  lwstall_cnt,
  output logic [CNT_W-1:0]  brstall_cnt,
  output logic [CNT_W-1:0]  mdstall_cnt
`endif
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            mdstall, lwstall, brstall;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (src != '0 && src == writeregM && regwriteM)      fwdSel = 2'b10;
    else if (src != '0 && src == writeregW && regwriteW) fwdSel = 2'b01;
    else                                                 fwdSel = 2'b00;
  endfunction

  assign forwardAE = fwdSel(rsE);
  assign forwardBE = fwdSel(rtE);
  assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  assign lwstall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
  assign brstall = branchD &&
                   ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
                    (memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // BUSY ignores mdstartE so the op sitting in EX cannot retrigger itself.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (mdstartE) begin
        stateNext = BUSY;
        cntNext   = CNT_LOAD;
      end
      BUSY: if (cnt != '0) cntNext = cnt - 1'b1;
            else           stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // rst gates the IDLE-state request so an abort drops the stall within the same cycle.
  always_comb begin
    mdstall = 1'b0;
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    case (state)
      IDLE:    mdstall = mdstartE && !rst;
      BUSY:    mdstall = (cnt != '0);
      default: mdstall = 1'b0;
    endcase
    if (mdstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwstall || brstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign mdbusy = (state == BUSY);

`ifdef HAZARD_PERF_EN
  // Each counter records only the cause that actually won the output priority.
  logic lwCause, brCause;
  assign lwCause = lwstall && !mdstall;
  assign brCause = brstall && !mdstall && !lwstall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lwstall_cnt <= '0;
      brstall_cnt <= '0;
      mdstall_cnt <= '0;
    end else begin
      if (lwCause && lwstall_cnt != '1) lwstall_cnt <= lwstall_cnt + 1'b1;
      if (brCause && brstall_cnt != '1) brstall_cnt <= brstall_cnt + 1'b1;
      if (mdstall && mdstall_cnt != '1) mdstall_cnt <= mdstall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and interlock unit for the 5-stage pipelined MIPS core; successor to the single-cycle-EX hazard unit. It generates forwarding selects for EX and the ID-stage branch comparator, load-use and branch-compare stalls, and a counter-driven interlock that freezes F/D/E while a multi-cycle multiply/divide occupies EX. It sits beside the datapath and drives the pipeline-register enables and flushes.

## Interface
- REG_AW, 5, register-address width.
- DIV_CYCLES, 32, number of stall cycles for a multi-cycle op in EX (legal range ≥1).
- CNT_W, 32, width of the performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rsD, rtD, rsE, rtE  in  REG_AW each  source registers in ID and EX.
- writeregE, writeregM, writeregW  in  REG_AW each  destination registers in EX, MEM and WB.
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enables.
- memtoregE, memtoregM  in  1 each  load in EX, load in MEM.
- branchD  in  1  branch in ID; its compare happens in ID.
- mdstartE  in  1  multi-cycle mult/div op in EX.
- forwardAE, forwardBE  out  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- forwardAD, forwardBD  out  1 each  ID compare operand taken from MEM.
- stallF, stallD, stallE  out  1 each  hold PC, IF/ID and ID/EX.
- flushE, flushM  out  1 each  bubble into ID/EX and EX/MEM.
- mdbusy  out  1  interlock FSM is in BUSY.
- lwstall_cnt, brstall_cnt, mdstall_cnt  out  CNT_W each  performance counters (present only with HAZARD_PERF_EN).

## Operation
- Register 0 is never forwarded and never causes a stall.
- forwardAE: 10 if rsE==writeregM and regwriteM; otherwise 01 if rsE==writeregW and regwriteW; otherwise 00. MEM has priority over WB. forwardBE is the same using rtE.
- forwardAD = rsD≠0 & rsD==writeregM & regwriteM. forwardBD is the same using rtD.
- lwstall = memtoregE & rtE≠0 & (rtE==rsD | rtE==rtD).
- brstall = branchD & [ (regwriteE & writeregE≠0 & writeregE∈{rsD,rtD}) | (memtoregM & writeregM≠0 & writeregM∈{rsD,rtD}) ].
- Interlock FSM has two states, IDLE and BUSY, and a counter cnt of width clog2(DIV_CYCLES+1).
  - In IDLE with mdstartE=1: mdstall is asserted this cycle; next state is BUSY with cnt←DIV_CYCLES−1.
  - In BUSY with cnt≠0: mdstall=1 and cnt decrements.
  - In BUSY with cnt==0: mdstall=0 and next state is IDLE. The op advances to MEM at the end of this cycle.
  - While in BUSY, mdstartE is ignored, so the same op cannot retrigger the FSM.
- Output priority:
  - If mdstall: stallF=stallD=stallE=1, flushE=0, flushM=1.
  - Else if lwstall|brstall: stallF=stallD=1, stallE=0, flushE=1, flushM=0.
  - Else all four are 0.
- mdbusy = (state==BUSY).

## Timing
- Forwarding and stall/flush outputs are combinational from the inputs and the FSM state. The FSM and the counters update on the rising edge of clk.
- rst (asynchronous): state←IDLE, cnt←0, all counters←0. With inputs low during reset, every output is 0.
- Reset asserted mid-BUSY aborts the interlock immediately, and mdstall drops in the same cycle.
- A mult/div op arriving in EX produces exactly DIV_CYCLES cycles of stallE; the op stays in EX for DIV_CYCLES+1 cycles.
- DIV_CYCLES=1 gives a single stall cycle, then BUSY with cnt==0 releases the pipeline.
- If lwstall/brstall coincides with mdstall, mdstall wins. The ID stall condition is re-evaluated after release.

## Configuration
- HAZARD_PERF_EN defined:
  - The three CNT_W counters exist.
  - A counter increments on each clk edge where its cause drives the outputs: lwstall without mdstall, brstall without mdstall or lwstall, or mdstall.
  - Counters saturate at all-ones and are cleared only by rst.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent; all other behaviour is identical.

## Test plan
- Forwarding: rsE=rtE=3, writeregM=3/regwriteM=1, writeregW=3/regwriteW=1 → forwardAE=forwardBE=10. Drop regwriteM → both 01. Set rsE=0 → forwardAE=00.
- Load-use: memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1, stallE=0. With rtE=0 → all 0.
- Branch: branchD=1, regwriteE=1, writeregE=rtD=7 → stall+flushE. Next cycle memtoregM=1, writeregM=7 → stall again. Then regwriteM=1 without a load, writeregM=7 → no stall, forwardBD=1.
- Mult/div, DIV_CYCLES=4: pulse mdstartE held until release → stallE high for exactly 4 cycles, flushM high those 4 cycles, mdbusy high for cycles 2–5, then all 0. Repeat with DIV_CYCLES=1 → 1 stall cycle.
- Priority/reset: mdstartE and lwstall together → flushE=0, stallE=1. Assert rst during cycle 3 of BUSY → mdbusy and stalls 0 at once. After release, the FSM is in IDLE.
- With HAZARD_PERF_EN and CNT_W=2: 5 load-use stalls → lwstall_cnt saturates at 3. rst → 0.
